// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with prescaler, period-aligned duty updates and linear fade
module pwm_multi #(
  parameter int CH      = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16,
  parameter int CH_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [CNT_W-1:0]   wr_duty,
  input  logic [CH-1:0]      fade_en,
  output logic [CH-1:0]      pwm_out,
  output logic               period_tick
);

  // cnt runs 0 .. 2^CNT_W-2, so an all-ones duty is never reached and reads as 100%
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0] r_pcnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_shadow [CH];
  logic [CNT_W-1:0]   r_active [CH];
  logic [CH-1:0]      r_pwm;
  logic               r_period_tick;

  logic w_tick;
  logic w_wrap;
  logic w_wr_valid;

  // >= rather than == so that lowering presc below the running count wraps at once
  assign w_tick     = (r_pcnt >= presc);
  assign w_wrap     = w_tick && (r_cnt == CNT_LAST);
  assign w_wr_valid = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt        <= '0;
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_pcnt        <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
      r_period_tick <= w_wrap;
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Active duty only moves on wrap; a write landing on the wrap cycle is seen one period later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_pwm <= '0;
    end else begin
      if (w_wr_valid) begin
        r_shadow[wr_ch] <= wr_duty;
      end
      for (int i = 0; i < CH; i++) begin
        if (w_wrap) begin
          if (!fade_en[i]) begin
            r_active[i] <= r_shadow[i];
          end else if (r_active[i] < r_shadow[i]) begin
            r_active[i] <= r_active[i] + CNT_W'(1);
          end else if (r_active[i] > r_shadow[i]) begin
            r_active[i] <= r_active[i] - CNT_W'(1);
          end
        end
        r_pwm[i] <= (r_cnt < r_active[i]);
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_period_tick;

endmodule
